// File: rtl/dp_seq_pkg.sv
// Shared types, widths and control encodings for the datapath sequencer.
package dp_seq_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned REG_W = 2;
  localparam int unsigned SR_W  = 2;
  localparam int unsigned ALU_W = 2;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_LDI = 3'b000,
    OP_MOV = 3'b001,
    OP_XOR = 3'b010,
    OP_AND = 3'b011,
    OP_SHL = 3'b100
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_T_SET   = 3'd1,
    ST_T_LOAD  = 3'd2,
    ST_W_SET   = 3'd3,
    ST_W_WRITE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [SR_W-1:0]  SR_IN    = 2'b00;
  localparam logic [SR_W-1:0]  SR_ALU   = 2'b01;
  localparam logic [SR_W-1:0]  SR_TMP   = 2'b10;

  localparam logic [ALU_W-1:0] ALU_XOR  = 2'b00;
  localparam logic [ALU_W-1:0] ALU_AND  = 2'b01;
  localparam logic [ALU_W-1:0] ALU_SHL  = 2'b10;
  localparam logic [ALU_W-1:0] ALU_PASS = 2'b11;

  localparam logic [SEL_W-1:0] TSEL_ALU = 3'b000;
  localparam logic [SEL_W-1:0] TSEL_R0  = 3'b001;
  localparam logic [SEL_W-1:0] TSEL_BIN = 3'b010;

  // Opcode is defined and, for two-operand ops, the source is not R0.
  function automatic logic is_legal(input logic [OP_W-1:0] op, input logic [REG_W-1:0] rs);
    case (op)
      OP_LDI, OP_SHL:         return 1'b1;
      OP_MOV, OP_XOR, OP_AND: return rs != '0;
      default:                return 1'b0;
    endcase
  endfunction

  // Ops that stage R0 into tmp before the ALU result is written back.
  function automatic logic needs_tmp(input logic [OP_W-1:0] op);
    return (op == OP_XOR) || (op == OP_AND) || (op == OP_SHL);
  endfunction

  // Bin mux index for a source register R1..R3.
  function automatic logic [SEL_W-1:0] bin_sel(input logic [REG_W-1:0] rs);
    return SEL_W'(rs - REG_W'(1));
  endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Host-side instruction handshake plus the control bundle driven into the datapath.
interface datapath_sequencer_if;
  import dp_seq_pkg::*;

  logic             start;
  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] rs;
  logic             busy;
  logic             done;
  logic             err;
  logic [SR_W-1:0]  sr;
  logic [REG_W-1:0] Rn;
  logic             w;
  logic [ALU_W-1:0] aluop;
  logic             lt;
  logic [SEL_W-1:0] tsel;
  logic [SEL_W-1:0] bsel;

  modport master (
    output start, op, rd, rs,
    input  busy, done, err, sr, Rn, w, aluop, lt, tsel, bsel
  );

  modport slave (
    input  start, op, rd, rs,
    output busy, done, err, sr, Rn, w, aluop, lt, tsel, bsel
  );
endinterface

// File: rtl/settle_timer.sv
// Down-counter that holds the write controls stable for SETTLE cycles.
module settle_timer
  import dp_seq_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic expired_c
);

  logic [CNT_W-1:0] cnt;

  // Load on entry to the settle window, count down while in it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(SETTLE);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired_c = (cnt <= CNT_W'(1));

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle controller sequencing the R0..R3/tmp/ALU datapath, one instruction per handshake.
module datapath_sequencer
  import dp_seq_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  datapath_sequencer_if.slave  bus
);

  state_t           state;
  logic [OP_W-1:0]  op_q;
  logic [REG_W-1:0] rd_q;
  logic [REG_W-1:0] rs_q;
  logic             err_q;
  logic             load_c;
  logic             dec_c;
  logic             expired_c;

  settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk       (clk),
    .reset     (reset),
    .load      (load_c),
    .dec       (dec_c),
    .expired_c (expired_c)
  );

  // Arm the timer on every entry into W_SET, run it while there.
  always_comb begin
    load_c = 1'b0;
    dec_c  = 1'b0;
    case (state)
      ST_IDLE:   load_c = bus.start && is_legal(bus.op, bus.rs) && !needs_tmp(bus.op);
      ST_T_LOAD: load_c = 1'b1;
      ST_W_SET:  dec_c  = 1'b1;
      default:   ;
    endcase
  end

  // Sequencer state and registered controls; outputs reflect the state just left.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      err_q     <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
      bus.w     <= 1'b0;
      bus.lt    <= 1'b0;
      bus.sr    <= SR_IN;
      bus.Rn    <= '0;
      bus.aluop <= ALU_PASS;
      bus.tsel  <= TSEL_ALU;
      bus.bsel  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.done <= 1'b0;
          bus.err  <= 1'b0;
          bus.w    <= 1'b0;
          bus.lt   <= 1'b0;
          if (bus.start) begin
            op_q     <= bus.op;
            rd_q     <= bus.rd;
            rs_q     <= bus.rs;
            bus.busy <= 1'b1;
            if (!is_legal(bus.op, bus.rs)) begin
              err_q <= 1'b1;
              state <= ST_DONE;
            end else if (needs_tmp(bus.op)) begin
              err_q <= 1'b0;
              state <= ST_T_SET;
            end else begin
              err_q <= 1'b0;
              state <= ST_W_SET;
            end
          end
        end
        ST_T_SET: begin
          bus.tsel <= TSEL_R0;
          bus.lt   <= 1'b0;
          state    <= ST_T_LOAD;
        end
        ST_T_LOAD: begin
          bus.lt <= 1'b1;
          state  <= ST_W_SET;
        end
        ST_W_SET: begin
          bus.w  <= 1'b0;
          bus.lt <= 1'b0;
          bus.Rn <= rd_q;
          case (op_q)
            OP_LDI: bus.sr <= SR_IN;
            OP_MOV: begin
              bus.sr    <= SR_ALU;
              bus.aluop <= ALU_PASS;
              bus.bsel  <= bin_sel(rs_q);
            end
            OP_XOR: begin
              bus.sr    <= SR_ALU;
              bus.aluop <= ALU_XOR;
              bus.bsel  <= bin_sel(rs_q);
            end
            OP_AND: begin
              bus.sr    <= SR_ALU;
              bus.aluop <= ALU_AND;
              bus.bsel  <= bin_sel(rs_q);
            end
            default: begin
              bus.sr    <= SR_ALU;
              bus.aluop <= ALU_SHL;
            end
          endcase
          if (expired_c) begin
            state <= ST_W_WRITE;
          end
        end
        ST_W_WRITE: begin
          bus.w <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          bus.w    <= 1'b0;
          bus.lt   <= 1'b0;
          bus.done <= 1'b1;
          bus.err  <= err_q;
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
